// File: rtl/fwd_hazard_if.sv
// Operand-forwarding / load-use hazard bundle between the ID stage and fwd_hazard_unit.
// The master is the pipeline side and the slave is the hazard unit.
interface fwd_hazard_if #(
  parameter int REG_AW  = 5,
  parameter int PERF_CW = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              flush;
  logic              ext_stall;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall;
  logic [PERF_CW-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush, ext_stall,
    input  fwd_a_sel, fwd_b_sel, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush, ext_stall,
    output fwd_a_sel, fwd_b_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects and 1-cycle load-use stall for the RV32I 5-stage core.
// Optional load-use stall counter enabled by defining FWD_PERF_EN.
module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int PERF_CW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  fwd_hazard_if.slave  hz
);

  logic [REG_AW-1:0] r_idex_rs1;
  logic [REG_AW-1:0] r_idex_rs2;
  logic              r_idex_use_rs1;
  logic              r_idex_use_rs2;
  logic [REG_AW-1:0] r_idex_rd;
  logic              r_idex_we;
  logic              r_idex_load;
  logic [REG_AW-1:0] r_exmem_rd;
  logic              r_exmem_we;
  logic [REG_AW-1:0] r_memwb_rd;
  logic              r_memwb_we;

  logic w_stall;
  logic w_bubble;

  // Youngest writer (EX/MEM) wins; x0 is never a forwarding source.
  function automatic logic [1:0] f_sel(
    input logic              use_rs,
    input logic [REG_AW-1:0] rs,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && em_we && (em_rd != '0) && (em_rd == rs)) begin
      sel = 2'b10;
    end else if (use_rs && mw_we && (mw_rd != '0) && (mw_rd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign hz.fwd_a_sel = f_sel(r_idex_use_rs1, r_idex_rs1, r_exmem_we, r_exmem_rd,
                              r_memwb_we, r_memwb_rd);
  assign hz.fwd_b_sel = f_sel(r_idex_use_rs2, r_idex_rs2, r_exmem_we, r_exmem_rd,
                              r_memwb_we, r_memwb_rd);

  assign w_stall = hz.id_valid & ~hz.flush & r_idex_load & (r_idex_rd != '0)
                 & ((hz.id_use_rs1 & (hz.id_rs1 == r_idex_rd))
                 |  (hz.id_use_rs2 & (hz.id_rs2 == r_idex_rd)));
  assign w_bubble = hz.flush | w_stall | ~hz.id_valid;
  assign hz.stall = w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_rs1     <= '0;
      r_idex_rs2     <= '0;
      r_idex_use_rs1 <= 1'b0;
      r_idex_use_rs2 <= 1'b0;
      r_idex_rd      <= '0;
      r_idex_we      <= 1'b0;
      r_idex_load    <= 1'b0;
      r_exmem_rd     <= '0;
      r_exmem_we     <= 1'b0;
      r_memwb_rd     <= '0;
      r_memwb_we     <= 1'b0;
    end else if (!hz.ext_stall) begin
      r_memwb_rd <= r_exmem_rd;
      r_memwb_we <= r_exmem_we;
      r_exmem_rd <= r_idex_rd;
      r_exmem_we <= r_idex_we;
      if (w_bubble) begin
        // Clearing the use bits too keeps a bubble from ever forwarding.
        r_idex_rs1     <= '0;
        r_idex_rs2     <= '0;
        r_idex_use_rs1 <= 1'b0;
        r_idex_use_rs2 <= 1'b0;
        r_idex_rd      <= '0;
        r_idex_we      <= 1'b0;
        r_idex_load    <= 1'b0;
      end else begin
        r_idex_rs1     <= hz.id_rs1;
        r_idex_rs2     <= hz.id_rs2;
        r_idex_use_rs1 <= hz.id_use_rs1;
        r_idex_use_rs2 <= hz.id_use_rs2;
        r_idex_rd      <= hz.id_rd;
        r_idex_we      <= hz.id_reg_write;
        r_idex_load    <= hz.id_mem_read;
      end
    end
  end

`ifdef FWD_PERF_EN
  logic [PERF_CW-1:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && !hz.ext_stall) begin
      r_stall_count <= r_stall_count + PERF_CW'(1);
    end
  end

  assign hz.stall_count = r_stall_count;
`else
  assign hz.stall_count = '0;
`endif

endmodule
